// File: rtl/uart_link_pkg.sv
// uart_link_pkg: shared FSM state types, oversampling constant and baud divisor helper for uart_link
`timescale 1ns/1ps
package uart_link_pkg;
   localparam int OVERSAMPLE = 16;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   // clocks per symbol, rounded to nearest
   function automatic int baud_div(input int clk_hz, input int rate);
      return (clk_hz + rate / 2) / rate;
   endfunction
endpackage

// File: rtl/uart_link_if.sv
// uart_link_if: frame-FIFO read side and transmit byte feed of uart_link
`timescale 1ns/1ps
interface uart_link_if #(
   parameter int FIFO_WIDTH = 8,
   parameter int FIFO_DEPTH = 11
);
   logic [FIFO_DEPTH*FIFO_WIDTH-1:0] fifo_data_out;
   logic                             fifo_rd_en;
   logic                             fifo_empty;
   logic                             fifo_full;
   logic                             fifo_almost_full;
   logic [7:0]                       din;
   logic                             wr_en;
   logic                             read_fifo_flag;
   modport master (
      input  fifo_data_out, fifo_empty, fifo_full, fifo_almost_full, read_fifo_flag,
      output fifo_rd_en, din, wr_en
   );
   modport slave (
      output fifo_data_out, fifo_empty, fifo_full, fifo_almost_full, read_fifo_flag,
      input  fifo_rd_en, din, wr_en
   );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running 16x receive tick, bit-rate transmit tick and a one-clock-early transmit pre-tick
`timescale 1ns/1ps
module uart_baud_gen
   import uart_link_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int UART_BAUD = 115200
) (
   input  logic clk_50m,
   input  logic reset_n,
   output logic rx_tick,
   output logic tx_tick,
   output logic tx_pre_tick
);
   localparam int TX_DIV = baud_div(CLK_HZ, UART_BAUD);
   localparam int RX_DIV = CLK_HZ / (OVERSAMPLE * UART_BAUD);
   localparam int TXW    = $clog2(TX_DIV + 1);
   localparam int RXW    = $clog2(RX_DIV + 1);
   logic [TXW-1:0] tx_div_cnt;
   logic [RXW-1:0] rx_div_cnt;
   assign tx_tick     = tx_div_cnt == TXW'(TX_DIV - 1);
   assign tx_pre_tick = tx_div_cnt == TXW'(TX_DIV - 2);
   assign rx_tick     = rx_div_cnt == RXW'(RX_DIV - 1);
   // both dividers wrap on their own tick
   always_ff @(posedge clk_50m or negedge reset_n) begin
      if (!reset_n) begin
         tx_div_cnt <= '0;
         rx_div_cnt <= '0;
      end else begin
         tx_div_cnt <= tx_tick ? '0 : tx_div_cnt + 1'b1;
         rx_div_cnt <= rx_tick ? '0 : rx_div_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/uart_link.sv
// uart_link: 16x UART receiver into a fixed-length command frame plus byte transmitter; UART_STOP_CHECK_EN drops bytes with a bad stop bit
`timescale 1ns/1ps
module uart_link
   import uart_link_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int UART_BAUD  = 115200,
   parameter int FIFO_WIDTH = 8,
   parameter int FIFO_DEPTH = 11
) (
   input  logic         clk_50m,
   input  logic         reset_n,
   input  logic         rx,
   output logic         tx,
   output logic         tx_busy,
   output logic         rx_frame_err,
   uart_link_if.slave   bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   logic                  rx_tick, tx_tick, tx_pre_tick;
   logic [1:0]            rx_sync;
   logic                  rx_s;
   rx_state_t             rx_state, rx_next;
   logic [3:0]            rx_cnt;
   logic [2:0]            rx_bits;
   logic [7:0]            rx_shreg;
   logic [FIFO_WIDTH-1:0] rx_byte;
   logic                  rx_stop_done, rx_push;
   logic [CW-1:0]         count, count_next;
   logic                  frame_clr;
   tx_state_t             tx_state, tx_next;
   logic [2:0]            tx_bits;
   logic [7:0]            tx_shreg;
   uart_baud_gen #(.CLK_HZ(CLK_HZ), .UART_BAUD(UART_BAUD)) u_baud (
      .clk_50m     (clk_50m),
      .reset_n     (reset_n),
      .rx_tick     (rx_tick),
      .tx_tick     (tx_tick),
      .tx_pre_tick (tx_pre_tick)
   );
   assign rx_s    = rx_sync[1];
   assign rx_byte = FIFO_WIDTH'(rx_shreg);
   // two-flop synchronizer, reset to the idle line level
   always_ff @(posedge clk_50m or negedge reset_n) begin
      if (!reset_n) rx_sync <= 2'b11;
      else          rx_sync <= {rx_sync[0], rx};
   end
   // receive state register
   always_ff @(posedge clk_50m or negedge reset_n) begin
      if (!reset_n) rx_state <= RX_IDLE;
      else          rx_state <= rx_next;
   end
   // receive next state: mid-start check, then one sample every 16 ticks
   always_comb begin
      rx_next = rx_state;
      if (rx_tick)
         case (rx_state)
            RX_IDLE:  rx_next = rx_s ? RX_IDLE : RX_START;
            RX_START: if (rx_cnt == 4'd7) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == 4'd15 && rx_bits == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_cnt == 4'd15) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
         endcase
   end
   // receive outputs: push at the mid-stop sample
   always_comb begin
      rx_stop_done = rx_state == RX_STOP && rx_tick && rx_cnt == 4'd15;
`ifdef UART_STOP_CHECK_EN
      rx_push      = rx_stop_done && rx_s;
      rx_frame_err = rx_stop_done && !rx_s;
`else
      rx_push      = rx_stop_done;
      rx_frame_err = 1'b0;
`endif
   end
   // receive datapath: tick counter restarts on every state change, data shifts in LSB first
   always_ff @(posedge clk_50m or negedge reset_n) begin
      if (!reset_n) begin
         rx_cnt   <= '0;
         rx_bits  <= '0;
         rx_shreg <= '0;
      end else if (rx_tick) begin
         rx_cnt <= (rx_next != rx_state) ? 4'd0 : rx_cnt + 4'd1;
         if (rx_state == RX_DATA && rx_cnt == 4'd15) begin
            rx_shreg <= {rx_s, rx_shreg[7:1]};
            rx_bits  <= rx_bits + 3'd1;
         end
      end
   end
   assign frame_clr = bus.fifo_rd_en && count != '0;
   // frame occupancy: a clear wins, a coincident push then lands in slot 0
   always_comb begin
      count_next = frame_clr ? (rx_push ? CW'(1) : '0)
                 : (rx_push && count != CW'(FIFO_DEPTH)) ? count + 1'b1 : count;
   end
   // frame storage and registered flags
   always_ff @(posedge clk_50m or negedge reset_n) begin
      if (!reset_n) begin
         count                <= '0;
         bus.fifo_data_out    <= '0;
         bus.fifo_empty       <= 1'b1;
         bus.fifo_full        <= 1'b0;
         bus.fifo_almost_full <= 1'b0;
      end else begin
         count                <= count_next;
         bus.fifo_empty       <= count_next == '0;
         bus.fifo_full        <= count_next == CW'(FIFO_DEPTH);
         bus.fifo_almost_full <= count_next >= CW'(FIFO_DEPTH - 1);
         if (frame_clr)
            bus.fifo_data_out <= rx_push ? (FIFO_DEPTH*FIFO_WIDTH)'(rx_byte) : '0;
         else if (rx_push && count != CW'(FIFO_DEPTH))
            for (int i = 0; i < FIFO_DEPTH; i++)
               if (count == CW'(i)) bus.fifo_data_out[i*FIFO_WIDTH +: FIFO_WIDTH] <= rx_byte;
      end
   end
   // transmit state register
   always_ff @(posedge clk_50m or negedge reset_n) begin
      if (!reset_n) tx_state <= TX_IDLE;
      else          tx_state <= tx_next;
   end
   // transmit next state: STOP leaves one clock early so the next byte is taken from IDLE on the boundary tick
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:  if (tx_tick && bus.wr_en) tx_next = TX_START;
         TX_START: if (tx_tick) tx_next = TX_DATA;
         TX_DATA:  if (tx_tick && tx_bits == 3'd7) tx_next = TX_STOP;
         TX_STOP:  if (tx_pre_tick) tx_next = TX_IDLE;
         default:  tx_next = TX_IDLE;
      endcase
   end
   // transmit outputs decoded from state so reset forces the line high at once
   always_comb begin
      bus.read_fifo_flag = tx_state == TX_IDLE && tx_tick && bus.wr_en;
      tx      = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_shreg[0] : 1'b1;
      tx_busy = tx_state != TX_IDLE;
   end
   // transmit datapath: latch on pop, shift out LSB first
   always_ff @(posedge clk_50m or negedge reset_n) begin
      if (!reset_n) begin
         tx_shreg <= '0;
         tx_bits  <= '0;
      end else if (bus.read_fifo_flag) begin
         tx_shreg <= bus.din;
         tx_bits  <= '0;
      end else if (tx_state == TX_DATA && tx_tick) begin
         tx_shreg <= {1'b0, tx_shreg[7:1]};
         tx_bits  <= tx_bits + 3'd1;
      end
   end
endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: scoreboard bench for the frame receiver and byte transmitter of uart_link
`timescale 1ns/1ps
module tb_uart_link;
   localparam int BIT_NS = 8680;
   localparam logic [87:0] FRAME11 = 88'h00_0000FFFF_0064_000000FF;
   typedef struct {
      logic [87:0] data;
      logic        empty;
      logic        afull;
      logic        full;
   } rx_exp_t;
   logic clk_50m = 1'b0;
   logic reset_n = 1'b0;
   logic rx = 1'b1;
   logic tx, tx_busy, rx_frame_err;
   int n_chk = 0;
   int n_fail = 0;
   int err_pulses = 0;
   int rd_pulses = 0;
   int tx_bytes = 0;
   longint cyc = 0;
   longint last_rd = 0;
   bit mon_en = 1'b1;
   rx_exp_t rx_q[$];
   string tag_q[$];
   logic [7:0] tx_q[$];
   rx_exp_t rx_e;
   string rx_tag;
   logic [9:0] tx_bits;
   logic [7:0] tx_want;
   logic tx_prev;
   event rx_chk;
   uart_link_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(11)) bus ();
   uart_link #(
      .CLK_HZ(50_000_000), .UART_BAUD(115200), .FIFO_WIDTH(8), .FIFO_DEPTH(11)
   ) dut (
      .clk_50m(clk_50m), .reset_n(reset_n), .rx(rx), .tx(tx),
      .tx_busy(tx_busy), .rx_frame_err(rx_frame_err), .bus(bus)
   );
   always #10 clk_50m = ~clk_50m;
   task automatic check(input string tag, input logic [87:0] act, input logic [87:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask
   task automatic timeout(input string tag);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out waiting on the DUT", tag);
   endtask
   task automatic expect_rx(input string tag, input logic [87:0] d, input logic e, input logic af, input logic f);
      rx_q.push_back('{d, e, af, f});
      tag_q.push_back(tag);
   endtask
   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(BIT_NS);
      end
      rx = stop;
      #(BIT_NS);
      rx = 1'b1;
   endtask
   task automatic rd_pulse();
      @(posedge clk_50m);
      #1 bus.fifo_rd_en = 1'b1;
      @(posedge clk_50m);
      #1 bus.fifo_rd_en = 1'b0;
   endtask
   task automatic wait_rd(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge clk_50m);
         if (bus.read_fifo_flag) ok = 1'b1;
      end
   endtask
   task automatic wait_busy(input logic lvl, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge clk_50m);
         if (tx_busy == lvl) ok = 1'b1;
      end
   endtask
   initial forever begin
      @(posedge clk_50m);
      cyc++;
   end
   // error pulses and pop strobes observed away from the active edge
   initial forever begin
      @(negedge clk_50m);
      if (rx_frame_err) err_pulses++;
      if (mon_en && bus.read_fifo_flag) begin
         rd_pulses++;
         check("rd_while_busy", 88'(tx_busy), 88'(0));
         if (rd_pulses == 2) check("rd_spacing", 88'(cyc - last_rd), 88'(4340));
         last_rd = cyc;
      end
   end
   // receive-side scoreboard: compare frame and flags when a receive stimulus completes
   initial forever begin
      @(rx_chk);
      if (rx_q.size() == 0) begin
         timeout("rx_unexpected");
      end else begin
         rx_e   = rx_q.pop_front();
         rx_tag = tag_q.pop_front();
         check({rx_tag, "_data"},  bus.fifo_data_out, rx_e.data);
         check({rx_tag, "_empty"}, 88'(bus.fifo_empty), 88'(rx_e.empty));
         check({rx_tag, "_afull"}, 88'(bus.fifo_almost_full), 88'(rx_e.afull));
         check({rx_tag, "_full"},  88'(bus.fifo_full), 88'(rx_e.full));
      end
   end
   // transmit-side scoreboard: decode each frame on tx at mid-bit and compare with the queued byte
   initial begin
      tx_prev = 1'b1;
      forever begin
         @(negedge clk_50m);
         if (mon_en && tx_prev && !tx) begin
            repeat (217) @(negedge clk_50m);
            for (int i = 0; i < 10; i++) begin
               tx_bits[i] = tx;
               if (i < 9) repeat (434) @(negedge clk_50m);
            end
            tx_bytes++;
            if (tx_q.size() == 0) begin
               timeout("tx_unexpected");
            end else begin
               tx_want = tx_q.pop_front();
               check("tx_frame", 88'(tx_bits), 88'({1'b1, tx_want, 1'b0}));
            end
         end
         tx_prev = tx;
      end
   end
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded 3 ms");
      $fatal(1, "watchdog");
   end
   initial begin
      bit ok;
      logic [7:0] seq [11];
      seq = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
      bus.fifo_rd_en = 1'b0;
      bus.din        = 8'h00;
      bus.wr_en      = 1'b0;
      #50;
      check("rst_tx",    88'(tx), 88'(1));
      check("rst_busy",  88'(tx_busy), 88'(0));
      check("rst_rdflag", 88'(bus.read_fifo_flag), 88'(0));
      check("rst_data",  bus.fifo_data_out, 88'(0));
      check("rst_empty", 88'(bus.fifo_empty), 88'(1));
      check("rst_full",  88'(bus.fifo_full), 88'(0));
      check("rst_afull", 88'(bus.fifo_almost_full), 88'(0));
      check("rst_err",   88'(rx_frame_err), 88'(0));
      #50 reset_n = 1'b1;
      repeat (5) @(posedge clk_50m);
      expect_rx("a5", 88'hA5, 1'b0, 1'b0, 1'b0);
      send_byte(8'hA5, 1'b1);
      -> rx_chk;
      expect_rx("clr_a5", 88'h0, 1'b1, 1'b0, 1'b0);
      rd_pulse();
      -> rx_chk;
      fork
         begin
            for (int i = 0; i < 11; i++) begin
               if (i == 9)  expect_rx("byte10", FRAME11, 1'b0, 1'b1, 1'b0);
               if (i == 10) expect_rx("byte11", FRAME11, 1'b0, 1'b1, 1'b1);
               send_byte(seq[i], 1'b1);
               if (i >= 9) -> rx_chk;
            end
            expect_rx("drop12", FRAME11, 1'b0, 1'b1, 1'b1);
            send_byte(8'h5A, 1'b1);
            -> rx_chk;
         end
         begin
            bus.din = 8'h3C;
            tx_q.push_back(8'h3C);
            bus.wr_en = 1'b1;
            wait_rd(1000, ok);
            if (!ok) timeout("rd_first");
            @(posedge clk_50m);
            #1 bus.din = 8'hC3;
            tx_q.push_back(8'hC3);
            wait_rd(5000, ok);
            if (!ok) timeout("rd_second");
            @(posedge clk_50m);
            #1 bus.wr_en = 1'b0;
            wait_busy(1'b0, 6000, ok);
            if (!ok) timeout("tx_idle");
            repeat (300) @(negedge clk_50m);
            check("rd_pulses", 88'(rd_pulses), 88'(2));
            check("tx_bytes",  88'(tx_bytes), 88'(2));
         end
      join
      expect_rx("clr_full", 88'h0, 1'b1, 1'b0, 1'b0);
      rd_pulse();
      -> rx_chk;
      expect_rx("glitch", 88'h0, 1'b1, 1'b0, 1'b0);
      rx = 1'b0;
      #2000 rx = 1'b1;
      #(3*BIT_NS);
      -> rx_chk;
`ifdef UART_STOP_CHECK_EN
      expect_rx("bad_stop", 88'h0, 1'b1, 1'b0, 1'b0);
`else
      expect_rx("bad_stop", 88'h81, 1'b0, 1'b0, 1'b0);
`endif
      send_byte(8'h81, 1'b0);
      -> rx_chk;
      #(BIT_NS);
`ifdef UART_STOP_CHECK_EN
      check("err_pulses", 88'(err_pulses), 88'(1));
`else
      check("err_pulses", 88'(err_pulses), 88'(0));
`endif
      mon_en    = 1'b0;
      bus.din   = 8'h55;
      bus.wr_en = 1'b1;
      wait_busy(1'b1, 1000, ok);
      if (!ok) timeout("busy_55");
      repeat (1000) @(negedge clk_50m);
      check("tx_mid_frame", 88'(tx), 88'(0));
      #3 reset_n = 1'b0;
      #1;
      check("abort_tx",    88'(tx), 88'(1));
      check("abort_busy",  88'(tx_busy), 88'(0));
      check("abort_data",  bus.fifo_data_out, 88'(0));
      check("abort_empty", 88'(bus.fifo_empty), 88'(1));
      bus.wr_en = 1'b0;
      #100 reset_n = 1'b1;
      repeat (10) @(posedge clk_50m);
      check("rx_q_drained", 88'(rx_q.size()), 88'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
